uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Buffered UART transmitter: accepts bytes on a valid/ready handshake into a small FIFO and serialises
//  them 8N1 (LSB first) on tx. Transmit end of the link the uart rx path receives; drives the uart rx
//  input in loopback benches. Uses the same 16x oversampled bit timing as the uart block.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD_RATE   9600        line rate, bit/s
//  FIFO_DEPTH  4           byte slots in the FIFO, power of two, >=2
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  reset       in   1  asynchronous, active-low reset (0 = in reset)
//  tx_data     in   8  byte to send, sampled when tx_valid && tx_ready
//  tx_valid    in   1  tx_data is valid
//  tx_ready    out  1  FIFO can accept a byte this cycle
//  tx          out  1  serial line, idles high
//  tx_busy     out  1  frame on the line or FIFO non-empty
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes waiting in FIFO (excludes byte in shifter)
// BEHAVIOUR
//  - Reset (async assert, sync release): tx=1, tx_busy=0, tx_ready=1, fifo_count=0, FSM IDLE, FIFO flushed.
//  - Bit time = BAUD_DIV*16 clocks, BAUD_DIV = CLK_FREQ/(BAUD_RATE*16) (integer div); 325 / 5200 at defaults.
//  - tx_ready = (fifo_count != FIFO_DEPTH), registered-state only; no combinational path from pop.
//  - Push on tx_valid && tx_ready; tx_data ignored otherwise. Push and pop same cycle: count unchanged.
//  - FSM IDLE -> START -> DATA(x8) -> STOP -> IDLE, or STOP -> START directly if FIFO non-empty.
//  - IDLE with FIFO non-empty: pop into shifter, clear baud divider, enter START; tx falls 1 clock after pop.
//  - Latency: handshake at edge N with FIFO empty and FSM IDLE -> tx low after edge N+2.
//  - START: tx=0 one bit time. DATA: tx=shift[0], shift right each bit time, 3-bit index wraps 7->done.
//  - STOP: tx=1 one bit time; back-to-back frames have no extra idle gap.
//  - tx_busy = (state != IDLE) || (fifo_count != 0).
//  - Reset mid-frame: tx returns high immediately, partial frame and FIFO contents discarded.
//  - FIFO: binary pointers width $clog2(FIFO_DEPTH), wrap naturally; count tracks occupancy 0..FIFO_DEPTH.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state between DATA and STOP, tx = even parity (XOR of 8 data bits),
//   frame 11 bit times (8E1). Not defined: no PARITY state, frame 10 bit times (8N1).
// STRUCTURE
//  - uart_pkg: OVERSAMPLE=16, baud_div(clk,baud) function, tx_state_t enum (IDLE,START,DATA,PARITY,STOP).
//  - Sub-module uart_baud_gen: divider + 16-tick counter, sync clear input, one-cycle bit_tick output.
//  - FIFO, FSM and shifter inline in uart_tx_fifo.
// TESTING (defaults, bit time 5200 clk)
//  1 push 0x9E idle -> tx low 2 clk later; line 0,0,1,1,1,1,0,0,1,1 each 5200 clk; tx_busy low after 52000 clk.
//  2 loopback tx->uart.rx, send 0x9E -> rx_valid with rx_out=0x9E.
//  3 push 0x01..0x06 back-to-back while idle -> 5 accepted, tx_ready low on 6th until first frame ends;
//    frames contiguous, no idle bits between stop and next start.
//  4 UART_TX_PARITY_EN, send 0x9E -> parity bit 1 then stop; send 0x03 -> parity 0; frame 57200 clk.
//  5 assert reset at bit 4 of a frame with 3 bytes queued -> tx=1 same cycle, fifo_count=0, tx_busy=0,
//    tx_ready=1; after release, line stays high with no frames.
//  6 tx_valid held while full, tx_data changed each cycle -> only bytes seen with tx_ready=1 are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, baud divider helper and transmitter state encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator: BAUD_DIV prescaler feeding a 16-tick oversample counter; bit_tick pulses
// for one clock at the end of every bit time. clear restarts the bit time from zero.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 325
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int DIV_W = $clog2(BAUD_DIV + 1);
    localparam int OVS_W = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [OVS_W-1:0] ovs_cnt;
    logic             os_tick;

    assign os_tick  = (div_cnt == DIV_LAST);
    assign bit_tick = os_tick && (ovs_cnt == OVS_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            ovs_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
            ovs_cnt <= '0;
        end else if (os_tick) begin
            div_cnt <= '0;
            ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding an 8N1 serialiser (LSB first).
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit (8E1).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             baud_clear;
    logic             bit_tick;

    tx_state_t        state;
    logic [7:0]       shift;
    logic [2:0]       bit_idx;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    // Handshake depends only on registered occupancy, never on this cycle's pop.
    assign fifo_empty = (fifo_count == '0);
    assign tx_ready   = (fifo_count != CNT_FULL);
    assign push       = tx_valid && tx_ready;
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_tick));
    assign baud_clear = pop && (state == IDLE);
    assign tx_busy    = (state != IDLE) || !fifo_empty;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // tx is registered from the current state, so the line trails the FSM by one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        state <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (pop) begin
                            shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^mem[rd_ptr];
`endif
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  tx <= parity_bit;
`endif
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued, a line monitor decodes frames and
// compares them in order. Short bit time (32 clocks) keeps the run small.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ   = 307_200;
    localparam int BAUD_RATE  = 9600;
    localparam int FIFO_DEPTH = 4;
    localparam int BT         = (CLK_FREQ / (BAUD_RATE * 16)) * 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int         start_cyc[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         frames_seen = 0;
    bit         mon_en = 1'b1;
    bit         m_act  = 1'b0;

    // Line monitor: detects a start bit, samples each bit at mid-bit and scores the frame.
    initial begin : monitor
        int         m_cnt;
        int         m_k;
        logic [10:0] m_bits;
        logic [7:0] got;
        logic [7:0] exp_b;
        m_cnt  = 0;
        m_bits = '0;
        forever begin
            @(negedge clk);
            if (!reset || !mon_en) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                if (tx === 1'b0) begin
                    m_act = 1'b1;
                    m_cnt = 0;
                    start_cyc.push_back(cyc);
                end
            end else begin
                m_cnt++;
                if (m_cnt % BT == BT / 2) begin
                    m_k = m_cnt / BT;
                    m_bits[m_k] = tx;
                    if (m_k == NB - 1) begin
                        m_act = 1'b0;
                        frames_seen++;
                        got = m_bits[8:1];
                        n_checks++;
                        if (m_bits[0] !== 1'b0 || m_bits[NB-1] !== 1'b1) begin
                            n_fail++;
                            $display("FAIL framing: start=%b stop=%b, required start=0 stop=1", m_bits[0], m_bits[NB-1]);
                        end
`ifdef UART_TX_PARITY_EN
                        n_checks++;
                        if (m_bits[9] !== ^got) begin
                            n_fail++;
                            $display("FAIL parity: byte %02h parity bit %b, required %b", got, m_bits[9], ^got);
                        end
`endif
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_frame: got %02h, required no frame", got);
                        end else begin
                            exp_b = exp_q.pop_front();
                            if (got !== exp_b) begin
                                n_fail++;
                                $display("FAIL frame_data: got %02h, required %02h", got, exp_b);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, output bit acc);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        acc      = tx_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(b);
        #1;
    endtask

    task automatic release_valid();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(posedge clk);
            n++;
            if (!tx_busy && !m_act && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
        n_checks++;
        if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
        n_checks++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", tx_ready); end
        n_checks++;
        if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        logic [10:0] line;
        logic [7:0]  b;
        bit          ok;
        b = 8'h9E;
`ifdef UART_TX_PARITY_EN
        line = {1'b1, ^b, b, 1'b0};
`else
        line = {1'b1, 1'b1, b, 1'b0};
`endif
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(b);
        #1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL latency_n1: tx %b one edge after handshake, required 1", tx); end
        @(posedge clk);
        #1;
        for (int c = 0; c < NB * BT; c++) begin
            if (c % BT == 0 || c % BT == BT - 1) begin
                n_checks++;
                if (tx !== line[c / BT]) begin
                    n_fail++;
                    $display("FAIL line_bit%0d: cycle %0d tx %b, required %b", c / BT, c, tx, line[c / BT]);
                end
            end
            if (c == BT) begin
                n_checks++;
                if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid: got %b, required 1", tx_busy); end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end: tx %b busy %b, required tx 1 busy 0", tx, tx_busy);
        end
        wait_drain(4 * NB * BT, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain_single: pending %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int acc_cnt;
        int s0;
        int n;
        bit acc;
        bit last_acc;
        bit ok;
        acc_cnt = 0;
        last_acc = 1'b0;
        s0 = start_cyc.size();
        for (int i = 1; i <= 6; i++) begin
            push_byte(8'(i), acc);
            if (acc) acc_cnt++;
            last_acc = acc;
        end
        n_checks++;
        if (acc_cnt != 5) begin n_fail++; $display("FAIL b2b_accepted: got %0d, required 5", acc_cnt); end
        n_checks++;
        if (last_acc !== 1'b0) begin n_fail++; $display("FAIL b2b_sixth_ready: accepted %b, required 0", last_acc); end
        n = 0;
        acc = 1'b0;
        while (!acc && n < NB * BT + 8) begin
            push_byte(8'h06, acc);
            n++;
        end
        release_valid();
        n_checks++;
        if (!acc) begin n_fail++; $display("FAIL b2b_sixth_late: waited %0d cycles, required accept by frame end", n); end
        wait_drain(10 * NB * BT, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain_b2b: pending %0d, required 0", exp_q.size()); end
        n_checks++;
        if (start_cyc.size() - s0 != 6) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d frames, required 6", start_cyc.size() - s0);
        end else begin
            for (int k = s0 + 1; k < s0 + 6; k++) begin
                n_checks++;
                if (start_cyc[k] - start_cyc[k-1] != NB * BT) begin
                    n_fail++;
                    $display("FAIL b2b_gap%0d: start spacing %0d, required %0d", k - s0, start_cyc[k] - start_cyc[k-1], NB * BT);
                end
            end
        end
    endtask

    task automatic test_parity_frames();
        int s0;
        bit acc;
        bit ok;
        s0 = start_cyc.size();
        push_byte(8'h9E, acc);
        push_byte(8'h03, acc);
        release_valid();
        wait_drain(4 * NB * BT, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain_parity: pending %0d, required 0", exp_q.size()); end
        n_checks++;
        if (start_cyc.size() - s0 != 2) begin
            n_fail++;
            $display("FAIL parity_frames: got %0d frames, required 2", start_cyc.size() - s0);
        end else if (start_cyc[s0+1] - start_cyc[s0] != NB * BT) begin
            n_fail++;
            $display("FAIL frame_length: got %0d clk, required %0d", start_cyc[s0+1] - start_cyc[s0], NB * BT);
        end
    endtask

    task automatic test_reset_mid_frame();
        int s0;
        int n;
        int lows;
        int f0;
        bit acc;
        s0 = start_cyc.size();
        for (int i = 0; i < 4; i++) push_byte(8'hA1 + 8'(i), acc);
        release_valid();
        n = 0;
        while (start_cyc.size() == s0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (start_cyc.size() == s0) begin n_fail++; $display("FAIL rst_no_start: got no frame, required one"); end
        repeat (5 * BT + 3) @(posedge clk);
        #1;
        n_checks++;
        if (fifo_count !== 3) begin n_fail++; $display("FAIL rst_queued: got %0d, required 3", fifo_count); end
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b, required 1", tx); end
        n_checks++;
        if (fifo_count !== '0 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_state: count %0d busy %b ready %b, required 0 0 1", fifo_count, tx_busy, tx_ready);
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        f0 = frames_seen;
        lows = 0;
        for (int c = 0; c < 2 * NB * BT; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0 || frames_seen != f0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_quiet: low cycles %0d frames %0d busy %b, required 0 0 0", lows, frames_seen - f0, tx_busy);
        end
    endtask

    task automatic test_full_hold();
        int acc_cnt;
        bit saw_full;
        bit acc;
        bit ok;
        acc_cnt = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 3 * NB * BT; c++) begin
            push_byte(8'($urandom), acc);
            if (acc) acc_cnt++;
            else saw_full = 1'b1;
        end
        release_valid();
        n_checks++;
        if (!saw_full || acc_cnt < FIFO_DEPTH + 2) begin
            n_fail++;
            $display("FAIL hold_full: saw_full %b accepted %0d, required 1 and >= %0d", saw_full, acc_cnt, FIFO_DEPTH + 2);
        end
        wait_drain((FIFO_DEPTH + 4) * NB * BT, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain_hold: pending %0d, required 0", exp_q.size()); end
    endtask

    initial begin
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity_frames();
        test_reset_mid_frame();
        test_full_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
